spell_commit: RTL and testbench



---
 rtl/spell_commit_pkg.sv | 23 ++
 rtl/spell_commit_if.sv | 49 ++++
 rtl/spell_stack_regfile.sv | 53 +++++
 rtl/spell_commit.sv | 114 +++++++++++
 tb/tb_spell_commit.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/spell_commit_pkg.sv
// spell_commit_pkg: shared types for the Spell commit/writeback stage.
// Holds memory write types, commit state encoding and the stack depth.
// Optional build macro used by this slice: SPELL_STACK_CLEAR_EN (see regfile).
package spell_commit_pkg;

  localparam int STACK_DEPTH = 32;
  localparam int SP_W        = 5;

  typedef enum logic [1:0] {
    MemoryTypeNone = 2'd0,
    MemoryTypeData = 2'd1,
    MemoryTypeCode = 2'd2,
    MemoryTypeRsvd = 2'd3
  } mem_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MEMWR = 2'd1,
    ST_DELAY = 2'd2,
    ST_SLEEP = 2'd3
  } commit_state_e;

endpackage

// File: rtl/spell_commit_if.sv
// spell_commit_if: bundles the execute->commit result bus, the memory write
// port and the architectural-state outputs. slave = commit stage side,
// master = surrounding core (execute, memory, fetch, wake/tick sources).
interface spell_commit_if;
  // execute results
  logic       commit_valid;
  logic       commit_ready;
  logic [7:0] next_pc;
  logic [4:0] next_sp;
  logic [1:0] stack_write_count;
  logic [7:0] set_stack_top;
  logic [7:0] set_stack_belowtop;
  logic [1:0] memory_write_type;
  logic [7:0] memory_write_addr;
  logic [7:0] memory_write_data;
  logic [7:0] delay_amount;
  logic       sleep;
  // timing / wake
  logic       delay_tick;
  logic       wake;
  // architectural state
  logic [7:0] pc;
  logic [4:0] sp;
  logic [7:0] stack_top;
  logic [7:0] stack_belowtop;
  // memory write port
  logic       mem_wr_valid;
  logic       mem_wr_ready;
  logic [1:0] mem_wr_type;
  logic [7:0] mem_wr_addr;
  logic [7:0] mem_wr_data;
  logic       sleeping;

  modport slave (
    input  commit_valid, next_pc, next_sp, stack_write_count, set_stack_top,
           set_stack_belowtop, memory_write_type, memory_write_addr,
           memory_write_data, delay_amount, sleep, delay_tick, wake, mem_wr_ready,
    output commit_ready, pc, sp, stack_top, stack_belowtop, mem_wr_valid,
           mem_wr_type, mem_wr_addr, mem_wr_data, sleeping
  );

  modport master (
    output commit_valid, next_pc, next_sp, stack_write_count, set_stack_top,
           set_stack_belowtop, memory_write_type, memory_write_addr,
           memory_write_data, delay_amount, sleep, delay_tick, wake, mem_wr_ready,
    input  commit_ready, pc, sp, stack_top, stack_belowtop, mem_wr_valid,
           mem_wr_type, mem_wr_addr, mem_wr_data, sleeping
  );
endinterface

// File: rtl/spell_stack_regfile.sv
// spell_stack_regfile: 32x8 data stack, two combinational read ports, two write ports.
// Ports: clk, reset, rd0/rd1 index+data, we0/we1 with index+data.
// SPELL_STACK_CLEAR_EN defined: reset zeroes every entry; otherwise entries have no reset.
module spell_stack_regfile
  import spell_commit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [SP_W-1:0] rd0_idx_i,
  output logic [7:0]      rd0_dat_o,
  input  logic [SP_W-1:0] rd1_idx_i,
  output logic [7:0]      rd1_dat_o,
  input  logic            we0_i,
  input  logic [SP_W-1:0] wr0_idx_i,
  input  logic [7:0]      wr0_dat_i,
  input  logic            we1_i,
  input  logic [SP_W-1:0] wr1_idx_i,
  input  logic [7:0]      wr1_dat_i
);

  logic [7:0] mem_q [STACK_DEPTH];
  logic [7:0] mem_d [STACK_DEPTH];

  assign rd0_dat_o = mem_q[rd0_idx_i];
  assign rd1_dat_o = mem_q[rd1_idx_i];

  // The two write indices are always next_sp-1 and next_sp-2, so they never collide.
  always_comb begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (we0_i && (wr0_idx_i == SP_W'(i))) mem_d[i] = wr0_dat_i;
      if (we1_i && (wr1_idx_i == SP_W'(i))) mem_d[i] = wr1_dat_i;
    end
  end

`ifdef SPELL_STACK_CLEAR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end
`else
  logic unused_reset;
  assign unused_reset = reset;

  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= mem_d[i];
  end
`endif

endmodule

// File: rtl/spell_commit.sv
// spell_commit: commit/writeback stage; updates pc/sp/stack, drives memory writes,
// runs the delay countdown and holds the core asleep until wake.
// Ports: clk, reset (async, active-high), bus (spell_commit_if.slave). Macro: SPELL_STACK_CLEAR_EN.
module spell_commit
  import spell_commit_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  spell_commit_if.slave  bus
);

  commit_state_e   state_q, state_d;
  logic [7:0]      pc_q, pc_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic [7:0]      cnt_q, cnt_d;
  mem_type_e       wr_type_q, wr_type_d;
  logic [7:0]      wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic            accept;

  // Ready is a pure state decode so no input can reach it combinationally.
  assign bus.commit_ready = (state_q == ST_IDLE);
  assign accept           = bus.commit_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    sp_d      = sp_q;
    cnt_d     = cnt_q;
    wr_type_d = wr_type_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          pc_d = bus.next_pc;
          sp_d = bus.next_sp;
          if (mem_type_e'(bus.memory_write_type) != MemoryTypeNone) begin
            state_d   = ST_MEMWR;
            wr_type_d = mem_type_e'(bus.memory_write_type);
            wr_addr_d = bus.memory_write_addr;
            wr_data_d = bus.memory_write_data;
          end else if (bus.delay_amount != 8'd0) begin
            state_d = ST_DELAY;
            cnt_d   = bus.delay_amount;
          end else if (bus.sleep) begin
            state_d = ST_SLEEP;
          end
        end
      end
      ST_MEMWR: begin
        if (bus.mem_wr_ready) state_d = ST_IDLE;
      end
      ST_DELAY: begin
        // A zero count here cannot happen via accept; treat it as done.
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else if (bus.delay_tick) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = ST_IDLE;
        end
      end
      ST_SLEEP: begin
        if (bus.wake) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= 8'h00;
      sp_q      <= '0;
      cnt_q     <= 8'h00;
      wr_type_q <= MemoryTypeNone;
      wr_addr_q <= 8'h00;
      wr_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      sp_q      <= sp_d;
      cnt_q     <= cnt_d;
      wr_type_q <= wr_type_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.sp           = sp_q;
  assign bus.mem_wr_valid = (state_q == ST_MEMWR);
  assign bus.mem_wr_type  = wr_type_q;
  assign bus.mem_wr_addr  = wr_addr_q;
  assign bus.mem_wr_data  = wr_data_q;
  assign bus.sleeping     = (state_q == ST_SLEEP);

  // Count 3 behaves as 2: bit 1 alone enables the second write.
  spell_stack_regfile u_stack (
    .clk       (clk),
    .reset     (reset),
    .rd0_idx_i (sp_q - 5'd1),
    .rd0_dat_o (bus.stack_top),
    .rd1_idx_i (sp_q - 5'd2),
    .rd1_dat_o (bus.stack_belowtop),
    .we0_i     (accept && (bus.stack_write_count != 2'd0)),
    .wr0_idx_i (bus.next_sp - 5'd1),
    .wr0_dat_i (bus.set_stack_top),
    .we1_i     (accept && bus.stack_write_count[1]),
    .wr1_idx_i (bus.next_sp - 5'd2),
    .wr1_dat_i (bus.set_stack_belowtop)
  );

endmodule

// File: tb/tb_spell_commit.sv
// tb_spell_commit: directed self-checking bench for spell_commit.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_spell_commit;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  spell_commit_if bus ();

  spell_commit u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.commit_valid       = 1'b0;
    bus.next_pc            = 8'h00;
    bus.next_sp            = 5'd0;
    bus.stack_write_count  = 2'd0;
    bus.set_stack_top      = 8'h00;
    bus.set_stack_belowtop = 8'h00;
    bus.memory_write_type  = 2'd0;
    bus.memory_write_addr  = 8'h00;
    bus.memory_write_data  = 8'h00;
    bus.delay_amount       = 8'h00;
    bus.sleep              = 1'b0;
  endtask

  // One-cycle commit pulse; returns 1 time unit after the accepting edge.
  task automatic commit(input logic [7:0] npc, input logic [4:0] nsp, input logic [1:0] cnt,
                        input logic [7:0] top, input logic [7:0] below,
                        input logic [1:0] wtype, input logic [7:0] waddr, input logic [7:0] wdata,
                        input logic [7:0] dly, input logic slp);
    bus.commit_valid       = 1'b1;
    bus.next_pc            = npc;
    bus.next_sp            = nsp;
    bus.stack_write_count  = cnt;
    bus.set_stack_top      = top;
    bus.set_stack_belowtop = below;
    bus.memory_write_type  = wtype;
    bus.memory_write_addr  = waddr;
    bus.memory_write_data  = wdata;
    bus.delay_amount       = dly;
    bus.sleep              = slp;
    step();
    idle_inputs();
  endtask

  initial begin
    int cyc;
    int ticks;
    reset            = 1'b1;
    bus.delay_tick   = 1'b0;
    bus.wake         = 1'b0;
    bus.mem_wr_ready = 1'b0;
    idle_inputs();
    step();
    step();

    // reset state
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_sp", bus.sp, 32'h0);
    chk("rst_ready", bus.commit_ready, 32'h1);
    chk("rst_valid", bus.mem_wr_valid, 32'h0);
    chk("rst_type", bus.mem_wr_type, 32'h0);
    chk("rst_addr", bus.mem_wr_addr, 32'h0);
    chk("rst_data", bus.mem_wr_data, 32'h0);
    chk("rst_sleeping", bus.sleeping, 32'h0);
`ifdef SPELL_STACK_CLEAR_EN
    chk("rst_top_clear", bus.stack_top, 32'h0);
    chk("rst_below_clear", bus.stack_belowtop, 32'h0);
`endif
    reset = 1'b0;
    step();

    // push: stack[0]=0x41
    commit(8'h01, 5'd1, 2'd1, 8'h41, 8'h00, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("push_sp", bus.sp, 32'h1);
    chk("push_top", bus.stack_top, 32'h41);
    chk("push_pc", bus.pc, 32'h01);
    chk("push_ready", bus.commit_ready, 32'h1);

    // swap: stack[1]=0x05, stack[0]=0x09
    commit(8'h02, 5'd2, 2'd2, 8'h05, 8'h09, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("swap_top", bus.stack_top, 32'h05);
    chk("swap_below", bus.stack_belowtop, 32'h09);
    chk("swap_ready", bus.commit_ready, 32'h1);
    chk("swap_pc", bus.pc, 32'h02);

    // count 3 behaves as 2: stack[3]=0x33, stack[2]=0x22
    commit(8'h03, 5'd4, 2'd3, 8'h33, 8'h22, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("cnt3_sp", bus.sp, 32'h4);
    chk("cnt3_top", bus.stack_top, 32'h33);
    chk("cnt3_below", bus.stack_belowtop, 32'h22);

    // sp wrap: next_sp=0 writes stack[31]
    commit(8'h04, 5'd0, 2'd1, 8'h5A, 8'h00, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("wrap0_top", bus.stack_top, 32'h5A);
    // next_sp=1, count 2: stack[0]=0x11, stack[31]=0x99
    commit(8'h05, 5'd1, 2'd2, 8'h11, 8'h99, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("wrap1_top", bus.stack_top, 32'h11);
    chk("wrap1_below", bus.stack_belowtop, 32'h99);

    // code write, ready low for 3 edges -> valid for 4 sample points
    bus.mem_wr_ready = 1'b0;
    commit(8'h20, 5'd1, 2'd0, 8'h00, 8'h00, 2'd2, 8'h10, 8'h7A, 8'h00, 1'b0);
    chk("cw_pc", bus.pc, 32'h20);
    for (int i = 0; i < 4; i++) begin
      chk("cw_valid", bus.mem_wr_valid, 32'h1);
      chk("cw_type", bus.mem_wr_type, 32'h2);
      chk("cw_addr", bus.mem_wr_addr, 32'h10);
      chk("cw_data", bus.mem_wr_data, 32'h7A);
      chk("cw_ready", bus.commit_ready, 32'h0);
      if (i == 3) bus.mem_wr_ready = 1'b1;
      step();
    end
    bus.mem_wr_ready = 1'b0;
    chk("cw_done_valid", bus.mem_wr_valid, 32'h0);
    chk("cw_done_ready", bus.commit_ready, 32'h1);

    // memory write outranks delay and sleep
    bus.mem_wr_ready = 1'b1;
    commit(8'h21, 5'd1, 2'd0, 8'h00, 8'h00, 2'd1, 8'h33, 8'h44, 8'h05, 1'b1);
    chk("prio_valid", bus.mem_wr_valid, 32'h1);
    chk("prio_type", bus.mem_wr_type, 32'h1);
    step();
    chk("prio_ready", bus.commit_ready, 32'h1);
    chk("prio_sleeping", bus.sleeping, 32'h0);
    bus.mem_wr_ready = 1'b0;

    // delay 3, tick every 2nd cycle
    commit(8'h22, 5'd1, 2'd0, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 8'h03, 1'b0);
    chk("dly_ready0", bus.commit_ready, 32'h0);
    cyc   = 0;
    ticks = 0;
    while (!bus.commit_ready && cyc < 50) begin
      bus.delay_tick = (cyc % 2 == 1);
      if (bus.delay_tick) ticks++;
      step();
      cyc++;
    end
    bus.delay_tick = 1'b0;
    chk("dly_ticks", ticks, 32'd3);
    chk("dly_cycles", cyc, 32'd6);

    // delay 2 with tick always high -> 2 cycles
    bus.delay_tick = 1'b1;
    commit(8'h23, 5'd1, 2'd0, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 8'h02, 1'b0);
    chk("dly2_c1", bus.commit_ready, 32'h0);
    step();
    chk("dly2_c2", bus.commit_ready, 32'h0);
    step();
    chk("dly2_done", bus.commit_ready, 32'h1);
    bus.delay_tick = 1'b0;

    // wake while idle is ignored
    bus.wake = 1'b1;
    step();
    bus.wake = 1'b0;
    chk("wake_idle_sleeping", bus.sleeping, 32'h0);
    chk("wake_idle_ready", bus.commit_ready, 32'h1);

    // sleep until wake
    commit(8'h24, 5'd1, 2'd0, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 8'h00, 1'b1);
    chk("slp_sleeping", bus.sleeping, 32'h1);
    chk("slp_ready", bus.commit_ready, 32'h0);
    step();
    chk("slp_hold", bus.sleeping, 32'h1);
    bus.wake = 1'b1;
    step();
    bus.wake = 1'b0;
    chk("slp_woke", bus.sleeping, 32'h0);
    chk("slp_woke_ready", bus.commit_ready, 32'h1);
    chk("slp_pc", bus.pc, 32'h24);

    // reset during MEMWR
    commit(8'h30, 5'd3, 2'd1, 8'hAB, 8'h00, 2'd1, 8'h55, 8'h66, 8'h00, 1'b0);
    chk("rmw_valid_pre", bus.mem_wr_valid, 32'h1);
    #1;
    reset = 1'b1;
    #1;
    chk("rmw_valid", bus.mem_wr_valid, 32'h0);
    chk("rmw_pc", bus.pc, 32'h0);
    chk("rmw_sp", bus.sp, 32'h0);
    chk("rmw_ready", bus.commit_ready, 32'h1);
`ifdef SPELL_STACK_CLEAR_EN
    chk("rmw_top_clear", bus.stack_top, 32'h0);
`endif
    step();
    reset = 1'b0;
    bus.mem_wr_ready = 1'b1;
    step();
    chk("rmw_after_valid", bus.mem_wr_valid, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
